// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired x0, two write ports, optional
// same-cycle write forwarding and a per-register pending-write scoreboard.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int RST_IDX = 1,
    localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREG-1:0]     busy_vec
);

    localparam bit POW2 = ((1 << AW) == NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:1] busy;
    logic [NREG-1:0] busy_full;

    assign busy_full = {busy, 1'b0};
    assign busy_vec  = busy_full;

    // Addresses beyond NREG only exist when NREG is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return POW2 || (int'(a) < NREG);
    endfunction

    function automatic logic wr_hit(input logic we, input logic [AW-1:0] wa,
                                    input logic [AW-1:0] a);
        return we && (wa == a) && (a != '0) && addr_ok(a);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (RST_IDX != 0 && i != 0) ? XLEN'(i) : '0;
            busy <= '0;
        end else begin
            // Port 1 is assigned last so it wins a same-address collision.
            if (wr_hit(we0, wa0, wa0)) regs[wa0] <= wd0;
            if (wr_hit(we1, wa1, wa1)) regs[wa1] <= wd1;
            for (int i = 1; i < NREG; i++) begin
                if (rsv_en && rsv_addr == AW'(i))
                    busy[i] <= 1'b1;
                else if (wr_hit(we0, wa0, AW'(i)) || wr_hit(we1, wa1, AW'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        logic            h0;
        logic            h1;

        assign a  = rd_addr[k*AW +: AW];
        assign h0 = wr_hit(we0, wa0, a);
        assign h1 = wr_hit(we1, wa1, a);

        always_comb begin
            d = '0;
            b = 1'b0;
            if (a != '0 && addr_ok(a)) begin
                d = regs[a];
                b = busy_full[a];
            end
            if (BYPASS != 0) begin
                if (h0) d = wd0;
                if (h1) d = wd1;
                // A write in flight retires the reservation unless re-reserved now.
                if ((h0 || h1) && !(rsv_en && rsv_addr == a)) b = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = d;
        assign rd_busy[k]              = b;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against three DUT builds.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default build: XLEN=32, NREG=32, NRD=2, BYPASS=1, RST_IDX=1
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, rsv_en;
    logic [4:0]  wa0, wa1, rsv_addr;
    logic [31:0] wd0, wd1;
    logic [31:0] busy_vec;

    regfile_mp dut1 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1),
        .wa1(wa1), .wd1(wd1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec)
    );

    // Wide builds: XLEN=64, NREG=16, NRD=3; dut2 forwards, dut3 does not
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data2, b_rd_data3;
    logic [2:0]   b_rd_busy2, b_rd_busy3;
    logic         b_we0, b_we1, b_rsv_en;
    logic [3:0]   b_wa0, b_wa1, b_rsv_addr;
    logic [63:0]  b_wd0, b_wd1;
    logic [15:0]  b_busy_vec2, b_busy_vec3;

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(1), .RST_IDX(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data2),
        .rd_busy(b_rd_busy2), .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1),
        .wa1(b_wa1), .wd1(b_wd1), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
        .busy_vec(b_busy_vec2)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(0), .RST_IDX(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data3),
        .rd_busy(b_rd_busy3), .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1),
        .wa1(b_wa1), .wd1(b_wd1), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
        .busy_vec(b_busy_vec3)
    );

    // Observation points selectable by the scoreboard
    localparam int S_RD0 = 0, S_RD1 = 1, S_BSY0 = 2, S_BSY1 = 3, S_BVEC = 4;
    localparam int S_B2 = 10, S_B3 = 20;

    int          q_cyc[$];
    int          q_sel[$];
    logic [63:0] q_exp[$];
    string       q_name[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            S_RD0:    return {32'h0, rd_data[31:0]};
            S_RD1:    return {32'h0, rd_data[63:32]};
            S_BSY0:   return {63'h0, rd_busy[0]};
            S_BSY1:   return {63'h0, rd_busy[1]};
            S_BVEC:   return {32'h0, busy_vec};
            S_B2 + 0: return b_rd_data2[63:0];
            S_B2 + 1: return b_rd_data2[127:64];
            S_B2 + 2: return b_rd_data2[191:128];
            S_B3 + 0: return b_rd_data3[63:0];
            S_B3 + 1: return b_rd_data3[127:64];
            S_B3 + 2: return b_rd_data3[191:128];
            default:  return 64'hx;
        endcase
    endfunction

    task automatic exp_push(input int sel, input logic [63:0] v, input string nm);
        q_cyc.push_back(cyc);
        q_sel.push_back(sel);
        q_exp.push_back(v);
        q_name.push_back(nm);
    endtask

    // Monitor: outputs are combinational, so each cycle is sampled mid-cycle.
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            int          c;
            int          s;
            logic [63:0] e;
            logic [63:0] a;
            string       nm;
            c  = q_cyc.pop_front();
            s  = q_sel.pop_front();
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_checks++;
            if (c < cyc) begin
                n_errors++;
                $display("FAIL %s: check missed its cycle %0d (now %0d)", nm, c, cyc);
            end else begin
                a = actual(s);
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL %s: got %h, expected %h", nm, a, e);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
        b_we0 = 1'b0; b_we1 = 1'b0; b_rsv_en = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        // Cycle 0: reset together with a write and reserve of x9 (reset wins)
        rst_n = 1'b0;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hDEADBEEF;
        we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        set_rd(5'd0, 5'd0);
        b_we0 = 1'b0; b_wa0 = 4'd0; b_wd0 = 64'h0;
        b_we1 = 1'b0; b_wa1 = 4'd0; b_wd1 = 64'h0;
        b_rsv_en = 1'b0; b_rsv_addr = 4'd0;
        b_rd_addr = '0;

        next_cycle();  // 1
        set_rd(5'd5, 5'd31);
        b_rd_addr = {3{4'd5}};
        exp_push(S_RD0, 64'h5, "reset_x5");
        exp_push(S_RD1, 64'h1F, "reset_x31");
        exp_push(S_BVEC, 64'h0, "reset_busy_vec");
        exp_push(S_B2 + 0, 64'd5, "wide_idx_x5_p0");
        exp_push(S_B3 + 2, 64'd0, "wide_zero_x5_p2");

        next_cycle();  // 2
        set_rd(5'd9, 5'd0);
        b_rd_addr = {3{4'd15}};
        exp_push(S_RD0, 64'h9, "reset_prio_x9");
        exp_push(S_RD1, 64'h0, "reset_x0");
        exp_push(S_BVEC, 64'h0, "reset_prio_busy");
        exp_push(S_B2 + 1, 64'd15, "wide_idx_x15_p1");

        next_cycle();  // 3: same-address dual write, port 1 wins
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5A5A5;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h12345678;
        set_rd(5'd3, 5'd4);
        b_we0 = 1'b1; b_wa0 = 4'd6; b_wd0 = 64'h0123456789ABCDEF;
        b_we1 = 1'b1; b_wa1 = 4'd6; b_wd1 = 64'hFEDCBA9876543210;
        b_rd_addr = {3{4'd6}};
        exp_push(S_RD0, 64'h12345678, "bypass_collide_x3");
        exp_push(S_RD1, 64'h4, "untouched_x4");
        for (int k = 0; k < 3; k++) begin
            exp_push(S_B2 + k, 64'hFEDCBA9876543210, $sformatf("wide_bypass_p%0d", k));
            exp_push(S_B3 + k, 64'h0, $sformatf("wide_nobypass_p%0d", k));
        end

        next_cycle();  // 4
        set_rd(5'd3, 5'd3);
        exp_push(S_RD0, 64'h12345678, "stored_collide_p0");
        exp_push(S_RD1, 64'h12345678, "stored_collide_p1");
        for (int k = 0; k < 3; k++) begin
            exp_push(S_B2 + k, 64'hFEDCBA9876543210, $sformatf("wide_stored2_p%0d", k));
            exp_push(S_B3 + k, 64'hFEDCBA9876543210, $sformatf("wide_stored3_p%0d", k));
        end

        next_cycle();  // 5: x0 write and reserve ignored; port 1 writes x10
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'hCAFEBABE;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        set_rd(5'd0, 5'd10);
        exp_push(S_RD0, 64'h0, "x0_write_bypass");
        exp_push(S_RD1, 64'hCAFEBABE, "bypass_x10");

        next_cycle();  // 6: dual write to different addresses
        we0 = 1'b1; wa0 = 5'd11; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h22222222;
        set_rd(5'd0, 5'd10);
        exp_push(S_RD0, 64'h0, "x0_after_write");
        exp_push(S_BVEC, 64'h0, "x0_reserve_ignored");
        exp_push(S_RD1, 64'hCAFEBABE, "stored_x10");

        next_cycle();  // 7: reserve x7
        rsv_en = 1'b1; rsv_addr = 5'd7;
        set_rd(5'd11, 5'd12);
        exp_push(S_RD0, 64'h11111111, "dual_write_x11");
        exp_push(S_RD1, 64'h22222222, "dual_write_x12");
        exp_push(S_BVEC, 64'h0, "pre_reserve_busy");

        next_cycle();  // 8: write x7 while re-reserving it
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h00000077;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        set_rd(5'd7, 5'd0);
        exp_push(S_BSY0, 64'h1, "rsv_x7_rd_busy");
        exp_push(S_BVEC, 64'h80, "rsv_x7_busy_vec");
        exp_push(S_RD0, 64'h77, "rsv_write_bypass");

        next_cycle();  // 9: write x7 alone
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h00000078;
        set_rd(5'd7, 5'd0);
        exp_push(S_BVEC, 64'h80, "reserve_wins_busy_vec");
        exp_push(S_BSY0, 64'h0, "write_clears_rd_busy");
        exp_push(S_RD0, 64'h78, "write_x7_bypass");

        next_cycle();  // 10: reserve x20
        rsv_en = 1'b1; rsv_addr = 5'd20;
        set_rd(5'd7, 5'd0);
        exp_push(S_BVEC, 64'h0, "busy_cleared_x7");
        exp_push(S_BSY0, 64'h0, "rd_busy_cleared_x7");
        exp_push(S_RD0, 64'h78, "stored_x7");

        next_cycle();  // 11: port 1 retires x20
        we1 = 1'b1; wa1 = 5'd20; wd1 = 32'h00002020;
        set_rd(5'd0, 5'd20);
        exp_push(S_BVEC, 64'h0010_0000, "rsv_x20_busy_vec");
        exp_push(S_BSY1, 64'h0, "p1_write_rd_busy");
        exp_push(S_RD1, 64'h2020, "p1_write_bypass");

        next_cycle();  // 12
        set_rd(5'd0, 5'd20);
        exp_push(S_BVEC, 64'h0, "p1_write_clears_busy");
        exp_push(S_RD1, 64'h2020, "stored_x20");

        next_cycle();
        next_cycle();
        while (q_cyc.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: never checked (cycle %0d)", q_name[0], q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_sel.pop_front());
            void'(q_exp.pop_front());
            void'(q_name.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
